output_port: RTL and testbench
==============================

# output_port

Router output stage, directly upstream of the next router's `input_port` on a link. It accepts flits from the switch traversal stage tagged with a downstream VC and buffers them in per-VC FIFOs. It sends at most one flit per cycle on `VALID`/`FLIT_O`, choosing VCs round-robin and gating each VC by the downstream `ON_OFF_n` flow-control lines. It pulses a VC release to the VC allocator when a tail flit leaves.

## Interface
Parameters:
- `flit_width`, 16, flit width in bits.
- `FIFO_DEPTH`, 2, entries per VC FIFO; power of two, at least 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `SW_VALID`  in  1  switch presents a flit this cycle.
- `SW_FLIT`  in  flit_width  flit from the crossbar.
- `SW_VC`  in  2  downstream VC allocated to this flit.
- `SW_READY`  out  4  bit v = VC v FIFO can accept a flit.
- `ON_OFF_0` … `ON_OFF_3`  in  1 each  from downstream input port; 1 = VC n may receive.
- `VALID`  out  1  flit on link this cycle.
- `FLIT_O`  out  flit_width  link flit.
- `VC_ID`  out  2  VC tag of `FLIT_O`.
- `VC_RELEASE`  out  4  one-cycle pulse, bit v = tail of VC v sent.
- `FLIT_COUNT`  out  16  present only with `OUTPUT_PORT_STATS_EN`.

## Operation
- Flit type is `flit[15:14]`:
  - 2'b10 = head.
  - 2'b00 = body.
  - 2'b01 = tail.
  - 2'b11 = head+tail (single-flit packet).
- Write: when `SW_VALID && SW_READY[SW_VC]`, `SW_FLIT` is pushed into FIFO `SW_VC`.
  - `SW_VALID` while `SW_READY[SW_VC]=0` is a protocol error. The flit is dropped and the FIFO is unchanged.
- `SW_READY[v] = !full[v] && rst`. It is combinational from the FIFO count and does not look ahead to a same-cycle pop.
- Eligibility: VC v is eligible when `!empty[v] && ON_OFF_v`.
- Arbitration is round-robin:
  - The search starts at `(last+1) mod 4`.
  - `last` updates only on a grant.
  - `last` resets to 3, so VC0 wins first.
- Grant: pop the head of the winning FIFO and register it into `FLIT_O`, `VC_ID`, `VALID=1`.
  - If the popped flit type is 01 or 11, also set `VC_RELEASE[v]=1` for that cycle.
- No eligible VC: `VALID=0`, `VC_RELEASE=0`. `FLIT_O` and `VC_ID` hold their last values.
- Simultaneous push and pop on the same non-full FIFO: both take effect and the count is unchanged.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values: `VALID=0`, `FLIT_O=0`, `VC_ID=0`, `VC_RELEASE=0`, `FLIT_COUNT=0`, all FIFOs empty, `last=3`, `SW_READY=4'b0000` while `rst=0`. `SW_READY=4'b1111` in the first cycle after release.
- Latency: a flit pushed on edge k can be granted on edge k+1. `VALID` is high in the cycle after edge k+1, so the minimum is 2 edges.
- `ON_OFF_n` is sampled combinationally in the arbitration cycle.
  - The downstream port must drop `ON_OFF_n` with at least 1 free slot of margin.
  - This block sends no flit on a VC during a cycle in which its `ON_OFF` is low.
- Throughput: one flit per cycle sustained when any VC is eligible.
- Reset mid-operation: FIFOs are flushed, buffered flits are lost, no release pulses are generated, and outputs take their reset values on that edge.

## Configuration
- `OUTPUT_PORT_STATS_EN` defined:
  - `FLIT_COUNT` port exists.
  - It increments on every grant and saturates at 16'hFFFF.
- Not defined:
  - No port and no counter logic.
  - All other behaviour is identical.

## Structure
- Shared package `noc_pkg`:
  - `FLIT_WIDTH` and `VC_NUM=4` constants.
  - Flit-type localparams HEAD, BODY, TAIL, HEAD_TAIL.
  - Flit-type field position [15:14].
- Sub-module `vc_fifo`:
  - Synchronous FIFO with push, pop, full, empty and head data.
  - Instantiated 4 times.
- Arbiter and output register live in `output_port`.

## Test plan
- After reset: `VALID=0`, `SW_READY=4'b1111`.
  - Push 16'hCA10 on VC0 with `ON_OFF_0=1`.
  - Expect: `VALID=1`, `FLIT_O=16'hCA10`, `VC_ID=0`, `VC_RELEASE=4'b0001` two edges later.
- Back-pressure on VC1:
  - With `ON_OFF_1=0`, push 2 flits on VC1.
  - Expect: `SW_READY[1]=0`, no `VALID`.
  - Raise `ON_OFF_1`; expect both flits out on consecutive cycles with `VC_ID=1`.
- Round-robin order:
  - Fill VC0, VC2 and VC3 with one body flit each (16'h0001, 16'h0002, 16'h0003), all ON.
  - Expect output order VC0, VC2, VC3 and `VC_RELEASE=0` throughout.
- Head-of-line isolation:
  - VC2 OFF holding 16'h8A3A while VC3 ON receives 16'h4A4B.
  - Expect 16'h4A4B sent with `VC_ID=3`; VC2 is still held.
- Reset mid-operation:
  - Assert `rst=0` with 2 flits buffered.
  - Expect all outputs at reset values next cycle and no flit emitted after release.
- With `OUTPUT_PORT_STATS_EN`:
  - Send 5 flits; expect `FLIT_COUNT=5`.
  - Force 65537 grants; expect `FLIT_COUNT=16'hFFFF`.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC constants: flit width, VC count and the flit-type field encoding.
package noc_pkg;
  localparam int FLIT_WIDTH = 16;
  localparam int VC_NUM     = 4;
  localparam int TYPE_MSB   = 15;
  localparam int TYPE_LSB   = 14;

  localparam logic [1:0] HEAD      = 2'b10;
  localparam logic [1:0] BODY      = 2'b00;
  localparam logic [1:0] TAIL      = 2'b01;
  localparam logic [1:0] HEAD_TAIL = 2'b11;

  // A packet ends (and its VC can be released) on a tail or a single-flit packet.
  function automatic logic is_tail(input logic [1:0] ftype);
    logic result;
    result = 1'b0;
    case (ftype)
      TAIL, HEAD_TAIL: result = 1'b1;
      HEAD, BODY:      result = 1'b0;
      default:         result = 1'b0;
    endcase
    return result;
  endfunction
endpackage

// File: rtl/vc_fifo.sv
// Per-VC synchronous FIFO; push is ignored when full and pop when empty.
module vc_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/output_port.sv
// Router output stage: per-VC buffering, round-robin link arbitration with
// on/off flow control. Define OUTPUT_PORT_STATS_EN to add the FLIT_COUNT counter.
module output_port
  import noc_pkg::*;
#(
  parameter int flit_width = FLIT_WIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SW_VALID,
  input  logic [flit_width-1:0] SW_FLIT,
  input  logic [1:0]            SW_VC,
  output logic [VC_NUM-1:0]     SW_READY,
  input  logic                  ON_OFF_0,
  input  logic                  ON_OFF_1,
  input  logic                  ON_OFF_2,
  input  logic                  ON_OFF_3,
  output logic                  VALID,
  output logic [flit_width-1:0] FLIT_O,
  output logic [1:0]            VC_ID,
  output logic [VC_NUM-1:0]     VC_RELEASE
`ifdef OUTPUT_PORT_STATS_EN
  ,
  output logic [15:0]           FLIT_COUNT
`endif
);
  logic [VC_NUM-1:0]     full;
  logic [VC_NUM-1:0]     empty;
  logic [VC_NUM-1:0]     on_off;
  logic [VC_NUM-1:0]     eligible;
  logic [VC_NUM-1:0]     push;
  logic [VC_NUM-1:0]     pop;
  logic [flit_width-1:0] head [VC_NUM];
  logic [flit_width-1:0] win_flit;
  logic [1:0]            last;
  logic [1:0]            grant_vc;
  logic [1:0]            idx;
  logic                  grant_any;

  assign on_off   = {ON_OFF_3, ON_OFF_2, ON_OFF_1, ON_OFF_0};
  assign eligible = ~empty & on_off;

  // Switch handshake: a flit transfers when SW_VALID && SW_READY[SW_VC]; READY
  // reflects only the current fill level, so a same-cycle pop does not open a slot.
  assign SW_READY = ~full & {VC_NUM{rst}};

  always_comb begin
    push = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      push[v] = SW_VALID && (SW_VC == 2'(v)) && SW_READY[v];
    end
  end

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    vc_fifo #(
      .WIDTH (flit_width),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[v]),
      .push_data (SW_FLIT),
      .pop       (pop[v]),
      .full      (full[v]),
      .empty     (empty[v]),
      .head      (head[v])
    );
  end

  // Round-robin search beginning just after the last winner; last is tried last.
  always_comb begin
    grant_any = 1'b0;
    grant_vc  = last;
    idx       = last;
    for (int i = 1; i <= VC_NUM; i++) begin
      idx = last + 2'(i);
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_vc  = idx;
      end
    end
  end

  assign pop      = grant_any ? (VC_NUM'(1) << grant_vc) : '0;
  assign win_flit = head[grant_vc];

  always_ff @(posedge clk) begin
    if (!rst) begin
      VALID      <= 1'b0;
      FLIT_O     <= '0;
      VC_ID      <= '0;
      VC_RELEASE <= '0;
      last       <= 2'd3;
    end else begin
      VALID      <= grant_any;
      VC_RELEASE <= '0;
      if (grant_any) begin
        FLIT_O <= win_flit;
        VC_ID  <= grant_vc;
        last   <= grant_vc;
        if (is_tail(win_flit[TYPE_MSB:TYPE_LSB])) begin
          VC_RELEASE <= VC_NUM'(1) << grant_vc;
        end
      end
    end
  end

`ifdef OUTPUT_PORT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      FLIT_COUNT <= '0;
    end else if (grant_any && (FLIT_COUNT != 16'hFFFF)) begin
      FLIT_COUNT <= FLIT_COUNT + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_output_port.sv
// Self-checking bench for output_port: queue-based link model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_output_port;
  localparam int W     = 16;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sw_valid;
  logic [W-1:0]  sw_flit;
  logic [1:0]    sw_vc;
  logic [3:0]    sw_ready;
  logic [3:0]    on_off;
  logic          valid;
  logic [W-1:0]  flit_o;
  logic [1:0]    vc_id;
  logic [3:0]    vc_release;
`ifdef OUTPUT_PORT_STATS_EN
  logic [15:0]   flit_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic checking = 1'b0;

  always #5 clk = ~clk;

  output_port #(
    .flit_width (W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .SW_VALID   (sw_valid),
    .SW_FLIT    (sw_flit),
    .SW_VC      (sw_vc),
    .SW_READY   (sw_ready),
    .ON_OFF_0   (on_off[0]),
    .ON_OFF_1   (on_off[1]),
    .ON_OFF_2   (on_off[2]),
    .ON_OFF_3   (on_off[3]),
    .VALID      (valid),
    .FLIT_O     (flit_o),
    .VC_ID      (vc_id),
    .VC_RELEASE (vc_release)
`ifdef OUTPUT_PORT_STATS_EN
    ,
    .FLIT_COUNT (flit_count)
`endif
  );

  // ---------------- behavioural model ----------------
  logic [W-1:0] exp_q [4][$];
  int           m_last;
  logic         m_valid;
  logic [W-1:0] m_flit;
  logic [1:0]   m_vc;
  logic [3:0]   m_rel;
  int           m_count;
  int           m_win;
  int           m_v;
  logic         m_push_ok;
  logic [3:0]   m_ready;

  initial begin
    m_last = 3; m_valid = 0; m_flit = '0; m_vc = '0; m_rel = '0; m_count = 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int v = 0; v < 4; v++) exp_q[v].delete();
      m_last = 3; m_valid = 0; m_flit = '0; m_vc = '0; m_rel = '0; m_count = 0;
    end else begin
      m_push_ok = sw_valid && (exp_q[sw_vc].size() < DEPTH);
      m_win = -1;
      for (int k = 1; k <= 4; k++) begin
        m_v = (m_last + k) % 4;
        if (m_win < 0 && exp_q[m_v].size() > 0 && on_off[m_v]) m_win = m_v;
      end
      m_rel   = '0;
      m_valid = (m_win >= 0);
      if (m_win >= 0) begin
        m_flit = exp_q[m_win].pop_front();
        m_vc   = m_win[1:0];
        m_last = m_win;
        if (m_flit[15:14] == 2'b01 || m_flit[15:14] == 2'b11) m_rel[m_win] = 1'b1;
        if (m_count < 65535) m_count++;
      end
      if (m_push_ok) exp_q[sw_vc].push_back(sw_flit);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      for (int v = 0; v < 4; v++) m_ready[v] = (exp_q[v].size() < DEPTH) && rst;
      check("valid", 32'(valid), 32'(m_valid));
      check("flit_o", 32'(flit_o), 32'(m_flit));
      check("vc_id", 32'(vc_id), 32'(m_vc));
      check("vc_release", 32'(vc_release), 32'(m_rel));
      check("sw_ready", 32'(sw_ready), 32'(m_ready));
`ifdef OUTPUT_PORT_STATS_EN
      check("flit_count", 32'(flit_count), 32'(m_count));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [1:0] vc, input logic [W-1:0] f);
    sw_valid = 1'b1;
    sw_vc    = vc;
    sw_flit  = f;
    tick();
    sw_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [W-1:0] f,
                            input logic [1:0] vc, input logic [3:0] rel);
    check({name, "_valid"}, 32'(valid), 32'(v));
    if (v) begin
      check({name, "_flit"}, 32'(flit_o), 32'(f));
      check({name, "_vc"}, 32'(vc_id), 32'(vc));
    end
    check({name, "_rel"}, 32'(vc_release), 32'(rel));
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    sw_valid = 1'b0; sw_flit = '0; sw_vc = '0; on_off = 4'b1111; rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checking = 1'b1;
    check("ready_in_reset", 32'(sw_ready), 32'h0);
    rst = 1'b1;
    #1;
    check("ready_after_release", 32'(sw_ready), 32'hF);
    check("valid_after_release", 32'(valid), 32'h0);
    #1;

    // Single-flit packet on VC0: visible two edges after the push edge.
    push(2'd0, 16'hCA10);
    check("t1_not_yet", 32'(valid), 32'h0);
    tick();
    expect_out("t1", 1'b1, 16'hCA10, 2'd0, 4'b0001);

    // Back-pressure on VC1, plus a dropped push into the full FIFO.
    on_off = 4'b1101;
    push(2'd1, 16'h8111);
    check("t2_hold1", 32'(valid), 32'h0);
    push(2'd1, 16'h4112);
    check("t2_ready1", 32'(sw_ready[1]), 32'h0);
    check("t2_hold2", 32'(valid), 32'h0);
    push(2'd1, 16'h0BAD);
    check("t2_hold3", 32'(valid), 32'h0);
    on_off = 4'b1111;
    tick();
    expect_out("t2a", 1'b1, 16'h8111, 2'd1, 4'b0000);
    tick();
    expect_out("t2b", 1'b1, 16'h4112, 2'd1, 4'b0010);
    tick();
    check("t2_drop", 32'(valid), 32'h0);

    // Reset with two flits buffered: nothing may emerge afterwards.
    on_off = 4'b0000;
    push(2'd2, 16'h8222);
    push(2'd3, 16'h4333);
    rst = 1'b0;
    #1;
    check("t5_ready_rst", 32'(sw_ready), 32'h0);
    tick();
    expect_out("t5_rst", 1'b0, 16'h0, 2'd0, 4'b0000);
    check("t5_flit_zero", 32'(flit_o), 32'h0);
    check("t5_vc_zero", 32'(vc_id), 32'h0);
    rst = 1'b1;
    on_off = 4'b1111;
    tick();
    check("t5_quiet1", 32'(valid), 32'h0);
    tick();
    check("t5_quiet2", 32'(valid), 32'h0);
    check("t5_ready", 32'(sw_ready), 32'hF);

    // Round-robin after reset: VC0 first, then VC2, VC3; body flits never release.
    on_off = 4'b0000;
    push(2'd0, 16'h0001);
    push(2'd2, 16'h0002);
    push(2'd3, 16'h0003);
    on_off = 4'b1111;
    tick();
    expect_out("t3a", 1'b1, 16'h0001, 2'd0, 4'b0000);
    tick();
    expect_out("t3b", 1'b1, 16'h0002, 2'd2, 4'b0000);
    tick();
    expect_out("t3c", 1'b1, 16'h0003, 2'd3, 4'b0000);
    tick();
    check("t3_idle", 32'(valid), 32'h0);

    // Head-of-line isolation: VC2 held off, VC3 tail passes it.
    on_off = 4'b1011;
    push(2'd2, 16'h8A3A);
    push(2'd3, 16'h4A4B);
    tick();
    expect_out("t4a", 1'b1, 16'h4A4B, 2'd3, 4'b1000);
    tick();
    check("t4_vc2_held", 32'(valid), 32'h0);
    on_off = 4'b1111;
    tick();
    expect_out("t4b", 1'b1, 16'h8A3A, 2'd2, 4'b0000);
    tick();

`ifdef OUTPUT_PORT_STATS_EN
    check("stats_five", 32'(flit_count), 32'd5);
    sw_valid = 1'b1; sw_vc = 2'd0; sw_flit = 16'h0000;
    repeat (65540) tick();
    sw_valid = 1'b0;
    tick();
    tick();
    check("stats_saturate", 32'(flit_count), 32'hFFFF);
`endif

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
